// File: rtl/key_scan_entry_module.sv
// 4x4 matrix keypad scanner: synchronizes the rows, walks a one-hot-low column on a 1 ms tick,
// debounces press and release, and shifts each accepted key code into a 4-nibble entry register.
module key_scan_entry_module #(
  parameter logic [16:0] T1MS        = 17'd49999,
  parameter logic [3:0]  DEBOUNCE_MS = 4'd10
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [3:0]  Row_Pin,
  output logic [3:0]  Col_Pin,
  output logic [3:0]  Key_Code,
  output logic        Key_Valid,
  output logic [15:0] Number_Sig
);

  typedef enum logic [2:0] {
    S_SCAN     = 3'd0,
    S_PRESS_DB = 3'd1,
    S_ACCEPT   = 3'd2,
    S_WAIT_REL = 3'd3,
    S_REL_DB   = 3'd4
  } state_t;

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [16:0] r_tick_cnt;
  state_t      r_state;
  logic [3:0]  r_db_cnt;
  logic [1:0]  r_col_idx;
  logic [1:0]  r_row_idx;
  logic [3:0]  r_col_pin;
  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic [15:0] r_number;

  logic        w_tick;
  logic        w_rows_idle;
  state_t      w_state_nxt;
  logic [3:0]  w_db_nxt;
  logic [3:0]  w_db_inc;
  logic [1:0]  w_col_nxt;
  logic [1:0]  w_row_nxt;
  logic        w_key_valid_nxt;
  logic [3:0]  w_key_code_nxt;
  logic [15:0] w_number_nxt;
  logic [3:0]  w_col_pin_nxt;

  // Lowest-numbered low row wins when several rows are pulled low together.
  function automatic logic [1:0] f_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [3:0] f_col_drive(input logic [1:0] idx);
    logic [3:0] drive;
    case (idx)
      2'd0:    drive = 4'b1110;
      2'd1:    drive = 4'b1101;
      2'd2:    drive = 4'b1011;
      2'd3:    drive = 4'b0111;
      default: drive = 4'b1110;
    endcase
    return drive;
  endfunction

  assign w_tick      = (r_tick_cnt == T1MS);
  assign w_rows_idle = (r_sync2 == 4'b1111);
  assign w_db_inc    = r_db_cnt + 4'd1;

  // Two-flop synchronizer for the asynchronous keypad rows.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= Row_Pin;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running 1 ms tick counter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_tick_cnt <= 17'd0;
    end else if (w_tick) begin
      r_tick_cnt <= 17'd0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 17'd1;
    end
  end

  // FSM state register together with the scan/debounce context it carries.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= S_SCAN;
      r_db_cnt  <= 4'd0;
      r_col_idx <= 2'd0;
      r_row_idx <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_db_cnt  <= w_db_nxt;
      r_col_idx <= w_col_nxt;
      r_row_idx <= w_row_nxt;
    end
  end

  // Next-state logic; everything but ACCEPT advances only on a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_db_nxt    = r_db_cnt;
    w_col_nxt   = r_col_idx;
    w_row_nxt   = r_row_idx;
    case (r_state)
      S_SCAN: begin
        if (w_tick && !w_rows_idle) begin
          w_row_nxt   = f_low_row(r_sync2);
          w_db_nxt    = 4'd0;
          w_state_nxt = S_PRESS_DB;
        end else if (w_tick) begin
          w_col_nxt = r_col_idx + 2'd1;
        end else begin
          w_col_nxt = r_col_idx;
        end
      end
      S_PRESS_DB: begin
        if (w_tick && !r_sync2[r_row_idx]) begin
          w_db_nxt = w_db_inc;
          if (w_db_inc == DEBOUNCE_MS) begin
            w_state_nxt = S_ACCEPT;
          end else begin
            w_state_nxt = S_PRESS_DB;
          end
        end else if (w_tick) begin
          w_state_nxt = S_SCAN;
        end else begin
          w_state_nxt = S_PRESS_DB;
        end
      end
      S_ACCEPT: begin
        w_state_nxt = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (w_tick && w_rows_idle) begin
          w_db_nxt    = 4'd0;
          w_state_nxt = S_REL_DB;
        end else begin
          w_state_nxt = S_WAIT_REL;
        end
      end
      S_REL_DB: begin
        if (w_tick && w_rows_idle) begin
          w_db_nxt = w_db_inc;
          if (w_db_inc == DEBOUNCE_MS) begin
            w_col_nxt   = 2'd0;
            w_state_nxt = S_SCAN;
          end else begin
            w_state_nxt = S_REL_DB;
          end
        end else if (w_tick) begin
          w_state_nxt = S_WAIT_REL;
        end else begin
          w_state_nxt = S_REL_DB;
        end
      end
      default: begin
        w_state_nxt = S_SCAN;
        w_db_nxt    = 4'd0;
        w_col_nxt   = 2'd0;
      end
    endcase
  end

  // Output decode; the strobe, code and entry register all land on the edge entering ACCEPT.
  always_comb begin
    w_key_valid_nxt = (w_state_nxt == S_ACCEPT);
    w_key_code_nxt  = r_key_code;
    w_number_nxt    = r_number;
    w_col_pin_nxt   = f_col_drive(w_col_nxt);
    if (w_key_valid_nxt) begin
      w_key_code_nxt = {r_row_idx, r_col_idx};
      w_number_nxt   = {r_number[11:0], r_row_idx, r_col_idx};
    end else begin
      w_key_code_nxt = r_key_code;
      w_number_nxt   = r_number;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_col_pin   <= 4'b1110;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_number    <= 16'h0000;
    end else begin
      r_col_pin   <= w_col_pin_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_number    <= w_number_nxt;
    end
  end

  assign Col_Pin    = r_col_pin;
  assign Key_Code   = r_key_code;
  assign Key_Valid  = r_key_valid;
  assign Number_Sig = r_number;

endmodule

// File: tb/tb_key_scan_entry_module.sv
// Bench for key_scan_entry_module: a keypad matrix model drives the rows from the driven column,
// and a scoreboard of expected key codes predicts Key_Code / Number_Sig every cycle.
module tb_key_scan_entry_module;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [3:0]  Row_Pin;
  logic [3:0]  Col_Pin;
  logic [3:0]  Key_Code;
  logic        Key_Valid;
  logic [15:0] Number_Sig;

  logic        key_down = 1'b0;
  logic [1:0]  key_row = 2'd0;
  logic [1:0]  key_col = 2'd0;

  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  m_code = 4'd0;
  logic [15:0] m_num = 16'h0000;
  logic        prev_valid = 1'b0;
  logic        chk_en = 1'b0;

  key_scan_entry_module #(
    .T1MS        (17'd9),
    .DEBOUNCE_MS (4'd2)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Row_Pin    (Row_Pin),
    .Col_Pin    (Col_Pin),
    .Key_Code   (Key_Code),
    .Key_Valid  (Key_Valid),
    .Number_Sig (Number_Sig)
  );

  always #5 CLK = ~CLK;

  // A pressed key shorts its row to its column, so the row reads low only while that column is driven.
  assign Row_Pin = (key_down && !Col_Pin[key_col]) ? ~(4'b0001 << key_row) : 4'b1111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Wait for the scan to switch onto column col (bounded).
  task automatic wait_col_entry(input int col);
    int t;
    t = 0;
    while (Col_Pin[col] == 1'b0 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    while (Col_Pin[col] == 1'b1 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check("col_entry_in_time", 32'(t < 100), 32'd1);
  endtask

  // Hold a key long enough to be accepted, then release long enough for release debounce.
  task automatic press(input logic [1:0] row, input logic [1:0] col);
    key_row = row;
    key_col = col;
    exp_q.push_back({row, col});
    key_down = 1'b1;
    wait_clks(120);
    key_down = 1'b0;
    wait_clks(60);
  endtask

  // Scoreboard: every strobe consumes one expected code; in every cycle the code and
  // entry register must equal the history of accepted codes.
  initial begin
    forever begin
      @(negedge CLK);
      if (RSTn && chk_en) begin
        if (Key_Valid) begin
          strobes++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got code %0h, expected no strobe", Key_Code);
          end else begin
            m_code = exp_q.pop_front();
            m_num  = {m_num[11:0], m_code};
          end
        end
        check("key_code", 32'(Key_Code), 32'(m_code));
        check("number_sig", 32'(Number_Sig), 32'(m_num));
        check("valid_one_cycle", 32'(prev_valid & Key_Valid), 32'd0);
        check("col_one_hot_low", 32'(Col_Pin == 4'b1110 || Col_Pin == 4'b1101 ||
                                     Col_Pin == 4'b1011 || Col_Pin == 4'b0111), 32'd1);
        prev_valid = Key_Valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] c;
    int t;

    // Reset values
    wait_clks(3);
    check("rst_col", 32'(Col_Pin), 32'h0000000E);
    check("rst_valid", 32'(Key_Valid), 32'd0);
    check("rst_code", 32'(Key_Code), 32'd0);
    check("rst_num", 32'(Number_Sig), 32'd0);
    RSTn = 1'b1;
    chk_en = 1'b1;

    // Idle scan: column moves every 10 clocks, first tick T1MS+1 clocks after release
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 9)  check("scan_k9", 32'(Col_Pin), 32'h0000000E);
      if (k == 10) check("scan_k10", 32'(Col_Pin), 32'h0000000D);
      if (k == 20) check("scan_k20", 32'(Col_Pin), 32'h0000000B);
      if (k == 30) check("scan_k30", 32'(Col_Pin), 32'h00000007);
      if (k == 40) check("scan_k40", 32'(Col_Pin), 32'h0000000E);
    end
    check("idle_no_strobe", 32'(strobes), 32'd0);
    check("idle_num", 32'(Number_Sig), 32'd0);

    // Row 2 / column 2 -> code A, then scan restarts from column 0 after release
    key_row = 2'd2;
    key_col = 2'd2;
    exp_q.push_back(4'hA);
    key_down = 1'b1;
    wait_clks(120);
    check("a_strobes", 32'(strobes), 32'd1);
    check("a_code", 32'(Key_Code), 32'h0000000A);
    check("a_num", 32'(Number_Sig), 32'h0000000A);
    check("a_held_col", 32'(Col_Pin), 32'h0000000B);
    key_down = 1'b0;
    t = 0;
    while (Col_Pin == 4'b1011 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check("a_restart_col", 32'(Col_Pin), 32'h0000000E);
    wait_clks(30);

    // Codes 1..5 in sequence
    press(2'd0, 2'd1);
    press(2'd0, 2'd2);
    press(2'd0, 2'd3);
    press(2'd1, 2'd0);
    press(2'd1, 2'd1);
    check("seq_strobes", 32'(strobes), 32'd6);
    check("seq_code", 32'(Key_Code), 32'h00000005);
    check("seq_num", 32'(Number_Sig), 32'h00002345);

    // One-tick bounce on row 2 / column 1: no strobe, scanning resumes
    wait_col_entry(1);
    key_row = 2'd2;
    key_col = 2'd1;
    key_down = 1'b1;
    wait_clks(10);
    key_down = 1'b0;
    wait_clks(50);
    check("bounce_strobes", 32'(strobes), 32'd6);
    check("bounce_num", 32'(Number_Sig), 32'h00002345);
    c = Col_Pin;
    wait_clks(10);
    check("bounce_scan_resumed", 32'(Col_Pin != c), 32'd1);

    // Key F held 50 ticks with a one-tick release glitch: single strobe
    key_row = 2'd3;
    key_col = 2'd3;
    exp_q.push_back(4'hF);
    key_down = 1'b1;
    wait_clks(200);
    key_down = 1'b0;
    wait_clks(10);
    key_down = 1'b1;
    wait_clks(290);
    key_down = 1'b0;
    wait_clks(60);
    check("hold_strobes", 32'(strobes), 32'd7);
    check("hold_code", 32'(Key_Code), 32'h0000000F);
    check("hold_num", 32'(Number_Sig), 32'h0000345F);

    // Reset during press debounce, key held through reset and detected afresh
    wait_col_entry(2);
    key_row = 2'd1;
    key_col = 2'd2;
    key_down = 1'b1;
    wait_clks(15);
    #2;
    RSTn = 1'b0;
    m_code = 4'd0;
    m_num = 16'h0000;
    prev_valid = 1'b0;
    #1;
    check("mid_rst_col", 32'(Col_Pin), 32'h0000000E);
    check("mid_rst_valid", 32'(Key_Valid), 32'd0);
    check("mid_rst_code", 32'(Key_Code), 32'd0);
    check("mid_rst_num", 32'(Number_Sig), 32'd0);
    wait_clks(3);
    RSTn = 1'b1;
    exp_q.push_back(4'h6);
    wait_clks(120);
    key_down = 1'b0;
    wait_clks(60);
    check("post_rst_strobes", 32'(strobes), 32'd8);
    check("post_rst_code", 32'(Key_Code), 32'h00000006);
    check("post_rst_num", 32'(Number_Sig), 32'h00000006);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_scan_entry_module.md
KEY_SCAN_ENTRY_MODULE -- requirements
Module: key_scan_entry_module

Interface
REQ-001 SHALL have parameter T1MS, default 17'd49999, meaning the 1 ms tick terminal count at 50 MHz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 4'd10, meaning the number of consecutive stable 1 ms ticks required for press and for release.
REQ-003 SHALL have port CLK, input, 1, system clock; all state changes on the rising edge.
REQ-004 SHALL have port RSTn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port Row_Pin, input, 4, keypad rows: active-low, pulled up externally, asynchronous to CLK.
REQ-006 SHALL have port Col_Pin, output, 4, keypad column drive: one-hot low.
REQ-007 SHALL have port Key_Code, output, 4, last accepted key code.
REQ-008 SHALL have port Key_Valid, output, 1, one-cycle strobe per accepted key.
REQ-009 SHALL have port Number_Sig, output, 16, hex entry register; 4 nibbles, most recent key in [3:0]; feeds the 4-digit display driver.

Function
REQ-010 SHALL pass Row_Pin through a 2-flop synchronizer; all row decisions use the synchronized value (rows_s).
REQ-011 SHALL run a free 17-bit counter 0..T1MS, wrapping to 0; tick is the cycle where counter == T1MS.
REQ-012 SHALL act only on tick cycles; state, column and counters otherwise hold. The sole exception is Key_Valid/Key_Code/Number_Sig (REQ-017).
REQ-013 SHALL implement states SCAN, PRESS_DB, ACCEPT, WAIT_REL, REL_DB.
REQ-014 SCAN, per tick:
- rows_s != 4'b1111: latch column index col_idx (0..3) and row index row_idx; row_idx = lowest-numbered low row when several are low. Hold Col_Pin, clear the debounce count, go to PRESS_DB.
- otherwise: advance the column 0->1->2->3->0. Col_Pin = 1110, 1101, 1011, 0111 for indices 0..3.
REQ-015 PRESS_DB, per tick:
- rows_s[row_idx] == 0: increment the debounce count.
- otherwise: return to SCAN with the column unchanged; the next tick resumes scanning from that column.
REQ-016 PRESS_DB SHALL go to ACCEPT on the tick where the debounce count reaches DEBOUNCE_MS.
REQ-017 ACCEPT SHALL last exactly one clock and does not wait for a tick. In that cycle:
- Key_Valid = 1
- Key_Code <= {row_idx[1:0], col_idx[1:0]}
- Number_Sig <= {Number_Sig[11:0], that code}; the oldest nibble is discarded, no saturation.
- next state is WAIT_REL.
REQ-018 WAIT_REL, per tick: rows_s == 4'b1111 -> clear the debounce count and go to REL_DB; otherwise hold. Col_Pin holds the pressed column.
REQ-019 REL_DB, per tick:
- rows_s == 4'b1111: increment the count; at DEBOUNCE_MS go to SCAN with column index 0.
- any row low: return to WAIT_REL.
REQ-020 SHALL produce exactly one Key_Valid per debounced press regardless of hold duration; a second key pressed while one is held SHALL be ignored.
REQ-021 Key_Valid SHALL be 0 in every cycle other than ACCEPT. Key_Code and Number_Sig SHALL change only in ACCEPT.
REQ-022 Outputs SHALL be registered; no combinational path from Row_Pin to any output.

Reset
REQ-023 While RSTn = 0, and immediately on assertion (including mid-debounce or mid-hold), the block SHALL hold:
- state = SCAN
- tick counter = 0, debounce count = 0
- column index = 0, Col_Pin = 4'b1110
- synchronizer flops = 4'b1111
- Key_Code = 0, Key_Valid = 0, Number_Sig = 16'h0000
REQ-024 After release, the first tick SHALL occur T1MS+1 clocks later; a key held through reset SHALL be detected normally as a new press.

Verification (bench overrides T1MS=9, DEBOUNCE_MS=2)
REQ-025 Reset, no keys -> Col_Pin cycles 1110, 1101, 1011, 0111, 1110 every 10 clocks; Key_Valid never asserts; Number_Sig = 0000.
REQ-026 Row 2 held low while Col_Pin = 1011, kept until accepted, then released -> one Key_Valid; Key_Code = 4'hA; Number_Sig = 000A; scanning restarts at 1110 after 2 high ticks.
REQ-027 Keys giving codes 1, 2, 3, 4, 5 entered in sequence -> Number_Sig = 2345 after the fifth strobe; five strobes total.
REQ-028 Row pulled low for one tick only (bounce) -> no Key_Valid; returns to SCAN; Number_Sig unchanged.
REQ-029 Key held for 50 ticks with a one-tick release glitch mid-hold -> exactly one Key_Valid.
REQ-030 RSTn asserted during PRESS_DB -> outputs immediately at reset values; no strobe; normal detection after release.
